// File: rtl/ahb_pkg.sv
// Shared AHB encodings, burst length helper and arbiter state type.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_e;

   typedef enum logic [1:0] {
      ARB    = 2'd0,
      BURST  = 2'd1,
      LOCKED = 2'd2
   } arb_state_e;

   // SINGLE and undefined-length INCR both report 1: neither pins the grant.
   function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
      case (hburst)
         HBURST_WRAP4, HBURST_INCR4:   burst_beats = 5'd4;
         HBURST_WRAP8, HBURST_INCR8:   burst_beats = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
         default:                      burst_beats = 5'd1;
      endcase
   endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbiter-facing AHB signals: requests and bus status in, grant/ownership out.
interface ahb_bus_arbiter_if #(
   parameter int NUM_MST = 4
);
   logic [NUM_MST-1:0] HBUSREQ;
   logic [NUM_MST-1:0] HLOCK;
   logic               HREADY;
   logic [1:0]         HTRANS;
   logic [2:0]         HBURST;
   logic [NUM_MST-1:0] HGRANT;
   logic [2:0]         HMASTER;
   logic               HMASTLOCK;
   logic               BRIDGE_GRANT;

   modport master (
      output HBUSREQ, HLOCK, HREADY, HTRANS, HBURST,
      input  HGRANT, HMASTER, HMASTLOCK, BRIDGE_GRANT
   );

   modport slave (
      input  HBUSREQ, HLOCK, HREADY, HTRANS, HBURST,
      output HGRANT, HMASTER, HMASTLOCK, BRIDGE_GRANT
   );
endinterface

// File: rtl/ahb_arb_pick.sv
// Combinational winner select: round-robin after ptr_i, or lowest index when
// ARB_FIXED_PRIO_EN is defined (pointer then passes through unchanged).
module ahb_arb_pick #(
   parameter int NUM_MST = 4
) (
   input  logic [NUM_MST-1:0] req_i,
   input  logic [2:0]         ptr_i,
   output logic [NUM_MST-1:0] win_o,
   output logic [2:0]         ptr_o,
   output logic               vld_o
);

   logic found;

   always_comb begin
      win_o = '0;
      ptr_o = ptr_i;
      found = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
      for (int j = 0; j < NUM_MST; j++) begin
         if (!found && req_i[j]) begin
            win_o[j] = 1'b1;
            found    = 1'b1;
         end
      end
`else
      // Offset k = NUM_MST lands back on ptr_i, so the last owner is tried last.
      for (int k = 1; k <= NUM_MST; k++) begin
         for (int j = 0; j < NUM_MST; j++) begin
            if (!found && req_i[j] && (j == ((int'(ptr_i) + k) % NUM_MST))) begin
               win_o[j] = 1'b1;
               ptr_o    = 3'(j);
               found    = 1'b1;
            end
         end
      end
`endif
   end

   assign vld_o = |req_i;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB arbiter holding grant over fixed bursts and locked sequences; drives BRIDGE_GRANT.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module ahb_bus_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_MST     = 4,
   parameter int DEFAULT_MST = 0,
   parameter int BRIDGE_IDX  = 1
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   ahb_bus_arbiter_if.slave    bus
);

   localparam logic [NUM_MST-1:0] DEFAULT_OH  = NUM_MST'(1) << DEFAULT_MST;
   localparam logic [2:0]         DEFAULT_IDX = 3'(DEFAULT_MST);

   arb_state_e         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [2:0]         ptr_q, ptr_d;
   logic [NUM_MST-1:0] grant_q, grant_d;
   logic [2:0]         hmaster_q, hmaster_d;
   logic               hmastlock_q, hmastlock_d;

   logic [NUM_MST-1:0] win_oh;
   logic [2:0]         win_ptr;
   logic               win_vld;
   logic [2:0]         gnt_idx;
   logic               owner_lock;
   logic               rearb;
   logic [NUM_MST-1:0] arb_grant;
   logic [2:0]         arb_ptr;

   ahb_arb_pick #(.NUM_MST(NUM_MST)) u_pick (
      .req_i (bus.HBUSREQ),
      .ptr_i (ptr_q),
      .win_o (win_oh),
      .ptr_o (win_ptr),
      .vld_o (win_vld)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (grant_q[i]) gnt_idx = 3'(i);
      end
   end

   assign owner_lock = |(bus.HLOCK & grant_q);
   assign arb_grant  = win_vld ? win_oh : DEFAULT_OH;
   assign arb_ptr    = (win_vld && (win_oh != grant_q)) ? win_ptr : ptr_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      hmaster_d   = hmaster_q;
      hmastlock_d = hmastlock_q;
      rearb       = 1'b0;

      if (bus.HREADY) begin
         hmaster_d   = gnt_idx;
         hmastlock_d = owner_lock;

         case (state_q)
            ARB: begin
               // Lock is tested first so a locked fixed burst ignores the count.
               if (owner_lock) begin
                  state_d = LOCKED;
               end else if ((bus.HTRANS == HTRANS_NONSEQ) && (burst_beats(bus.HBURST) > 5'd1)) begin
                  state_d = BURST;
                  cnt_d   = 4'(burst_beats(bus.HBURST) - 5'd1);
               end else begin
                  rearb = 1'b1;
               end
            end
            BURST: begin
               case (bus.HTRANS)
                  HTRANS_SEQ: begin
                     if (cnt_q == 4'd1) begin
                        state_d = ARB;
                        cnt_d   = '0;
                        rearb   = 1'b1;
                     end else begin
                        cnt_d = cnt_q - 4'd1;
                     end
                  end
                  HTRANS_BUSY: ;
                  default: begin
                     state_d = ARB;
                     cnt_d   = '0;
                     rearb   = 1'b1;
                  end
               endcase
            end
            LOCKED: begin
               if (!owner_lock && ((bus.HTRANS == HTRANS_IDLE) || (bus.HTRANS == HTRANS_NONSEQ))) begin
                  state_d = ARB;
                  rearb   = 1'b1;
               end
            end
            default: state_d = ARB;
         endcase

         if (rearb) begin
            grant_d = arb_grant;
            ptr_d   = arb_ptr;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q     <= ARB;
         cnt_q       <= '0;
         ptr_q       <= DEFAULT_IDX;
         grant_q     <= DEFAULT_OH;
         hmaster_q   <= DEFAULT_IDX;
         hmastlock_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         hmaster_q   <= hmaster_d;
         hmastlock_q <= hmastlock_d;
      end
   end

   assign bus.HGRANT       = grant_q;
   assign bus.HMASTER      = hmaster_q;
   assign bus.HMASTLOCK    = hmastlock_q;
   assign bus.BRIDGE_GRANT = grant_q[BRIDGE_IDX];

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed vector bench for ahb_bus_arbiter (4 masters, default 0, bridge 1).
module tb_ahb_bus_arbiter;

   localparam logic [1:0] T_I = 2'd0, T_B = 2'd1, T_N = 2'd2, T_S = 2'd3;
   localparam logic [2:0] B_SGL = 3'd0, B_W8 = 3'd4, B_I4 = 3'd3, B_I8 = 3'd5;

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic [3:0] lock;
      logic       rdy;
      logic [1:0] trans;
      logic [2:0] burst;
      logic [3:0] grant;
      logic [2:0] mst;
      logic       mlock;
      logic       bgnt;
   } vec_t;

   logic HCLK = 1'b0;
   logic HRESETn;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   always #5 HCLK = ~HCLK;

   ahb_bus_arbiter_if #(.NUM_MST(4)) bus ();

   ahb_bus_arbiter #(
      .NUM_MST     (4),
      .DEFAULT_MST (0),
      .BRIDGE_IDX  (1)
   ) dut (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .bus     (bus)
   );

   function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] l, logic y, logic [1:0] t,
                               logic [2:0] b, logic [3:0] g, logic [2:0] m, logic ml, logic bg);
      vec_t v;
      v.rst_n = r; v.req = q; v.lock = l; v.rdy = y; v.trans = t; v.burst = b;
      v.grant = g; v.mst = m; v.mlock = ml; v.bgnt = bg;
      return v;
   endfunction

   task automatic check(input string nm, input int n, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d got %0h want %0h", nm, n, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] q, input logic [3:0] l, input logic y,
                        input logic [1:0] t, input logic [2:0] b);
      HRESETn     = r;
      bus.HBUSREQ = q;
      bus.HLOCK   = l;
      bus.HREADY  = y;
      bus.HTRANS  = t;
      bus.HBURST  = b;
   endtask

   task automatic check_outs(input int n, input logic [3:0] g, input logic [2:0] m,
                             input logic ml, input logic bg);
      check("hgrant", n, 8'(bus.HGRANT), 8'(g));
      check("hmaster", n, 8'(bus.HMASTER), 8'(m));
      check("hmastlock", n, 8'(bus.HMASTLOCK), 8'(ml));
      check("bridge_grant", n, 8'(bus.BRIDGE_GRANT), 8'(bg));
   endtask

   initial begin
      // reset, then release into round-robin with everyone requesting
      vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b1, T_I, B_SGL, 4'b0001, 3'd0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b1, T_I, B_SGL, 4'b0001, 3'd0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b1111, 4'b0000, 1'b1, T_I, B_SGL, 4'b0010, 3'd0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'b1011, 4'b0000, 1'b1, T_N, B_SGL, 4'b1000, 3'd1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b1011, 4'b0000, 1'b1, T_N, B_SGL, 4'b0001, 3'd3, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b1011, 4'b0000, 1'b1, T_N, B_SGL, 4'b0010, 3'd0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'b1011, 4'b0000, 1'b0, T_N, B_SGL, 4'b0010, 3'd0, 1'b0, 1'b1));
      // sole requester keeps grant; nobody requesting falls back to master 0
      vecs.push_back(mk(1'b1, 4'b0010, 4'b0000, 1'b1, T_N, B_SGL, 4'b0010, 3'd1, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b1, T_I, B_SGL, 4'b0001, 3'd1, 1'b0, 1'b0));
      // INCR8 on master 2 with BUSY, two wait states and a dropped request
      vecs.push_back(mk(1'b1, 4'b0100, 4'b0000, 1'b1, T_I, B_SGL, 4'b0100, 3'd0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b1, T_N, B_I8,  4'b0100, 3'd2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b1, T_S, B_I8,  4'b0100, 3'd2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b1, T_S, B_I8,  4'b0100, 3'd2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b1, T_B, B_I8,  4'b0100, 3'd2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b0, T_S, B_I8,  4'b0100, 3'd2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b0, T_S, B_I8,  4'b0100, 3'd2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b1, T_S, B_I8,  4'b0100, 3'd2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0001, 4'b0000, 1'b1, T_S, B_I8,  4'b0100, 3'd2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0001, 4'b0000, 1'b1, T_S, B_I8,  4'b0100, 3'd2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b1, T_S, B_I8,  4'b0100, 3'd2, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0101, 4'b0000, 1'b1, T_S, B_I8,  4'b0001, 3'd2, 1'b0, 1'b0));
      // INCR4 terminated early by IDLE; following SEQ must re-arbitrate
      vecs.push_back(mk(1'b1, 4'b0011, 4'b0000, 1'b1, T_N, B_I4,  4'b0001, 3'd0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0011, 4'b0000, 1'b1, T_S, B_I4,  4'b0001, 3'd0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0011, 4'b0000, 1'b1, T_I, B_I4,  4'b0010, 3'd0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'b0011, 4'b0000, 1'b1, T_S, B_SGL, 4'b0001, 3'd1, 1'b0, 1'b0));
      // locked sequence by master 1 with masters 0 and 2 waiting
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0010, 1'b1, T_I, B_SGL, 4'b0010, 3'd0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0010, 1'b1, T_N, B_SGL, 4'b0010, 3'd1, 1'b1, 1'b1));
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0010, 1'b1, T_N, B_SGL, 4'b0010, 3'd1, 1'b1, 1'b1));
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0010, 1'b1, T_N, B_SGL, 4'b0010, 3'd1, 1'b1, 1'b1));
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0000, 1'b1, T_I, B_SGL, 4'b0100, 3'd1, 1'b0, 1'b0));
      // locked INCR4 runs past its beat count, then sync reset abandons it
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0100, 1'b1, T_N, B_I4,  4'b0100, 3'd2, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0100, 1'b1, T_S, B_I4,  4'b0100, 3'd2, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0100, 1'b1, T_S, B_I4,  4'b0100, 3'd2, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0100, 1'b1, T_S, B_I4,  4'b0100, 3'd2, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0100, 1'b1, T_S, B_I4,  4'b0100, 3'd2, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 4'b0111, 4'b0100, 1'b1, T_S, B_I4,  4'b0001, 3'd0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 4'b0111, 4'b0000, 1'b1, T_I, B_SGL, 4'b0010, 3'd0, 1'b0, 1'b1));

      drive(1'b0, 4'b1111, 4'b0000, 1'b1, T_I, B_SGL);
      #2;
      for (int n = 0; n < vecs.size(); n++) begin
         drive(vecs[n].rst_n, vecs[n].req, vecs[n].lock, vecs[n].rdy, vecs[n].trans, vecs[n].burst);
         @(posedge HCLK);
         #1;
         check_outs(n, vecs[n].grant, vecs[n].mst, vecs[n].mlock, vecs[n].bgnt);
      end

      // reset pulse that misses every clock edge must not disturb anything
      #2 HRESETn = 1'b0;
      #1 check_outs(100, 4'b0010, 3'd0, 1'b0, 1'b1);
      #1 HRESETn = 1'b1;
      drive(1'b1, 4'b0111, 4'b0000, 1'b0, T_I, B_SGL);
      @(posedge HCLK);
      #1 check_outs(101, 4'b0010, 3'd0, 1'b0, 1'b1);

      // WRAP8 from master 1: grant held for 7 SEQs, moves to master 2 on the last
      drive(1'b1, 4'b0111, 4'b0000, 1'b1, T_N, B_W8);
      @(posedge HCLK);
      #1 check_outs(102, 4'b0010, 3'd1, 1'b0, 1'b1);
      for (int k = 0; k < 7; k++) begin
         drive(1'b1, 4'b0111, 4'b0000, 1'b1, T_S, B_W8);
         @(posedge HCLK);
         #1;
         if (k < 6) check_outs(110 + k, 4'b0010, 3'd1, 1'b0, 1'b1);
         else       check_outs(110 + k, 4'b0100, 3'd1, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
